// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 key schedule controller.
package aes_pkg;

  // Round key as four 32-bit words, word 0 most significant.
  typedef logic [0:3][31:0] rk_t;

  typedef enum logic [2:0] {
    StIdle,
    StPresent,
    StSub,
    StExpand,
    StDone
  } ks_state_e;

  localparam logic [7:0] RconInit = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads 0x01 at schedule start and steps by xtime per round.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] rcon
);

  // rcon state; load wins over advance
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rcon <= RconInit;
    end else if (load) begin
      rcon <= RconInit;
    end else if (advance) begin
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: presents round keys one at a time over a
// valid/ready handshake and borrows a shared S-box for each SubWord step.
// Optional build macro AES_KSCHED_STALL_CNT_EN enables the S-box wait counter.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [0:3][31:0] key_i,
  output logic [0:3][31:0] rk_o,
  output logic [3:0]       rk_idx_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             sbox_req_o,
  input  logic             sbox_gnt_i,
  output logic [31:0]      sbox_word_o,
  input  logic [31:0]      sbox_word_i,
  output logic [15:0]      stall_cnt_o
);

  ks_state_e  state_q;
  rk_t        rk_q;
  rk_t        rk_next;
  logic [3:0] idx_q;
  logic [31:0] sub_q;
  logic       rk_valid_q;
  logic       busy_q;
  logic       done_q;
  logic       sbox_req_q;
  logic [7:0] rcon;
  logic       start_acc;
  logic       rcon_adv;
  logic       last_round;

  assign start_acc  = (state_q == StIdle) && start_i;
  assign rcon_adv   = (state_q == StExpand) && !abort_i;
  assign last_round = idx_q >= 4'(NUM_ROUNDS);

  aes_rcon_gen u_rcon_gen (
    .clk     (clk),
    .nrst    (nrst),
    .load    (start_acc),
    .advance (rcon_adv),
    .rcon    (rcon)
  );

  // Next round key from the current key, captured SubWord and rcon
  always_comb begin
    rk_next    = '0;
    rk_next[0] = rk_q[0] ^ sub_q ^ {rcon, 24'h0};
    rk_next[1] = rk_q[1] ^ rk_next[0];
    rk_next[2] = rk_q[2] ^ rk_next[1];
    rk_next[3] = rk_q[3] ^ rk_next[2];
  end

  // Schedule FSM with registered handshake/status outputs; abort overrides everything
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      rk_q       <= '0;
      idx_q      <= '0;
      sub_q      <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sbox_req_q <= 1'b0;
    end else if (abort_i && (state_q != StIdle)) begin
      state_q    <= StIdle;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sbox_req_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            rk_q       <= key_i;
            idx_q      <= '0;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StPresent;
          end
        end
        StPresent: begin
          if (rk_ready_i) begin
            rk_valid_q <= 1'b0;
            if (last_round) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              sbox_req_q <= 1'b1;
              state_q    <= StSub;
            end
          end
        end
        StSub: begin
          if (sbox_gnt_i) begin
            sub_q      <= sbox_word_i;
            sbox_req_q <= 1'b0;
            state_q    <= StExpand;
          end
        end
        StExpand: begin
          rk_q       <= rk_next;
          idx_q      <= idx_q + 4'd1;
          rk_valid_q <= 1'b1;
          state_q    <= StPresent;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rk_o        = rk_q;
  assign rk_idx_o    = idx_q;
  assign rk_valid_o  = rk_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sbox_req_o  = sbox_req_q;
  assign sbox_word_o = {rk_q[3][23:0], rk_q[3][31:24]};

`ifdef AES_KSCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of SUB cycles spent waiting for the S-box
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if ((state_q == StSub) && !sbox_gnt_i && (stall_q != 16'hffff)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: FIPS-197 vector, random keys with
// random handshakes against a word-array key-expansion model, plus corner sequences.
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (10 rounds)
  logic start, abort, ready, gnt;
  logic [0:3][31:0] key, rk;
  logic [3:0] idx;
  logic valid, busy, done, req;
  logic [31:0] sw_o, sw_i;
  logic [15:0] stall;

  // Single-round DUT
  logic start1, abort1, ready1, gnt1;
  logic [0:3][31:0] key1, rk1;
  logic [3:0] idx1;
  logic valid1, busy1, done1, req1;
  logic [31:0] sw_o1, sw_i1;
  logic [15:0] stall1;

  int n_vec = 0;
  int n_miss = 0;
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] FipsKey = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FipsK1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FipsK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h00;
    if (b != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, b);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_pow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < n; j++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  // FIPS-197 word-array key expansion
  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_pow(i / 4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  assign sw_i  = sub_word(sw_o);
  assign sw_i1 = sub_word(sw_o1);

  aes_key_sched_ctrl #(.NUM_ROUNDS(10)) u_dut (
    .clk (clk), .nrst (nrst), .start_i (start), .abort_i (abort), .key_i (key),
    .rk_o (rk), .rk_idx_o (idx), .rk_valid_o (valid), .rk_ready_i (ready),
    .busy_o (busy), .done_o (done), .sbox_req_o (req), .sbox_gnt_i (gnt),
    .sbox_word_o (sw_o), .sbox_word_i (sw_i), .stall_cnt_o (stall)
  );

  aes_key_sched_ctrl #(.NUM_ROUNDS(1)) u_dut1 (
    .clk (clk), .nrst (nrst), .start_i (start1), .abort_i (abort1), .key_i (key1),
    .rk_o (rk1), .rk_idx_o (idx1), .rk_valid_o (valid1), .rk_ready_i (ready1),
    .busy_o (busy1), .done_o (done1), .sbox_req_o (req1), .sbox_gnt_i (gnt1),
    .sbox_word_o (sw_o1), .sbox_word_i (sw_i1), .stall_cnt_o (stall1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rk"}, rk, '0);
    chk({tag, "_idx"}, idx, '0);
    chk({tag, "_valid"}, valid, '0);
    chk({tag, "_busy"}, busy, '0);
    chk({tag, "_done"}, done, '0);
    chk({tag, "_req"}, req, '0);
    chk({tag, "_stall"}, stall, '0);
  endtask

  // Modes: 0 ready/grant always, 1 random ready/grant, 2 grant withheld 7 cycles
  // per round, 3 ready held low 5 cycles at idx 3
  task automatic run_sched(input logic [127:0] k, input int mode,
                           input logic [127:0] e1, input logic [127:0] e10);
    int nexp;
    int cyc;
    int hold;
    int gwait;
    int stall_m;
    bit fin;
    bit first;
    nexp = 0; cyc = 0; hold = 0; gwait = 0; stall_m = 0; fin = 0; first = 1;
    compute_model(k);
    key = k;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      cyc++;
      chk("busy_in_sched", busy, 1'b1);
      if (valid) begin
        chk("rk", rk, exp_rk[nexp]);
        chk("rk_idx", idx, nexp);
        chk("no_req_while_valid", req, 1'b0);
        if (first && nexp == 1) chk("rk_idx1_known", rk, e1);
        if (first && nexp == 10) chk("rk_idx10_known", rk, e10);
        first = 0;
        if (mode == 1) ready = ($urandom_range(0, 2) != 0);
        else if (mode == 3 && nexp == 3 && hold < 5) begin
          ready = 1'b0;
          hold++;
        end else ready = 1'b1;
        if (ready) begin
          nexp++;
          first = 1;
        end
      end else begin
        ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (req) begin
        if (mode == 1) gnt = 1'($urandom_range(0, 1));
        else if (mode == 2) begin
          if (gwait < 7) begin
            gnt = 1'b0;
            gwait++;
          end else begin
            gnt = 1'b1;
            gwait = 0;
          end
        end else gnt = 1'b1;
        if (!gnt) stall_m++;
      end else begin
        gnt = 1'b0;
      end
      if (done) begin
        chk("done_after_last_key", nexp, 11);
        chk("done_valid_low", valid, 1'b0);
        fin = 1;
      end
      step();
    end
    ready = 1'b0;
    gnt = 1'b0;
    if (!fin) chk("sched_timeout", 1'b0, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    if (mode == 3) chk("ready_hold_cycles", hold, 5);
`ifdef AES_KSCHED_STALL_CNT_EN
    chk("stall_cnt", stall, stall_m);
    if (mode == 2) chk("stall_cnt_70", stall, 70);
`else
    chk("stall_cnt", stall, 0);
`endif
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] exp1;
    logic [127:0] exp10;
    int           mode;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cyc;
    logic [127:0] rkey;
    start = 0; abort = 0; ready = 0; gnt = 0; key = '0;
    start1 = 0; abort1 = 0; ready1 = 0; gnt1 = 0; key1 = '0;

    // Reset state
    #6;
    chk_reset_outputs("reset");
    #6 nrst = 1'b1;
    step();
    chk_reset_outputs("post_reset");

    // Vector table
    tbl[0] = '{FipsKey, FipsK1, FipsK10, 0};
    tbl[1] = '{FipsKey, FipsK1, FipsK10, 3};
    tbl[2] = '{FipsKey, FipsK1, FipsK10, 2};
    for (int i = 3; i < 6; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      compute_model(rkey);
      tbl[i] = '{rkey, exp_rk[1], exp_rk[10], 1};
    end
    for (int i = 0; i < 6; i++) begin
      run_sched(tbl[i].key, tbl[i].mode, tbl[i].exp1, tbl[i].exp10);
      step();
    end

    // Abort in SUB at idx 4, with a grant in the same cycle
    compute_model(FipsKey);
    key = FipsKey;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(req && idx == 4) && cyc < 200) begin
      ready = valid;
      gnt = req && (idx != 4);
      step();
      cyc++;
    end
    if (cyc >= 200) chk("abort_wait_timeout", 1'b0, 1'b1);
    chk("abort_at_idx", idx, 4);
    ready = 1'b0;
    abort = 1'b1;
    gnt = 1'b1;
    step();
    abort = 1'b0;
    gnt = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", valid, 1'b0);
    chk("abort_req", req, 1'b0);
    chk("abort_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", done, 1'b0);
    end
    run_sched(FipsKey, 0, FipsK1, FipsK10);

    // Reset asserted mid-EXPAND
    key = FipsKey;
    start = 1'b1;
    step();
    start = 1'b0;
    ready = 1'b1;
    gnt = 1'b1;
    cyc = 0;
    while (!(req && idx == 1) && cyc < 50) begin
      step();
      cyc++;
    end
    if (cyc >= 50) chk("expand_wait_timeout", 1'b0, 1'b1);
    step();
    chk("in_expand_busy", busy, 1'b1);
    chk("in_expand_valid", valid, 1'b0);
    #1 nrst = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    #1 nrst = 1'b1;
    ready = 1'b0;
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_valid", valid, 1'b0);
      chk("post_reset_done", done, 1'b0);
      chk("post_reset_busy", busy, 1'b0);
    end

    // start while busy is ignored
    key = FipsKey;
    start = 1'b1;
    step();
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy_rk", rk, FipsKey);
    chk("start_busy_idx", idx, 0);
    chk("start_busy_valid", valid, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("start_busy_abort_idle", busy, 1'b0);

    // Single-round instance
    key1 = FipsKey;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    ready1 = 1'b1;
    gnt1 = 1'b1;
    chk("r1_k0", rk1, FipsKey);
    chk("r1_k0_valid", valid1, 1'b1);
    step();
    chk("r1_sub_valid", valid1, 1'b0);
    chk("r1_sub_req", req1, 1'b1);
    step();
    chk("r1_expand_valid", valid1, 1'b0);
    step();
    chk("r1_k1_valid", valid1, 1'b1);
    chk("r1_k1_idx", idx1, 1);
    chk("r1_k1", rk1, FipsK1);
    step();
    chk("r1_done", done1, 1'b1);
    chk("r1_done_valid", valid1, 1'b0);
    chk("r1_done_busy", busy1, 1'b1);
    step();
    chk("r1_done_pulse", done1, 1'b0);
    chk("r1_idle_busy", busy1, 1'b0);
    ready1 = 1'b0;
    gnt1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
